// File: rtl/mmio_bridge.sv
// Data-side bridge: serves a small MMIO window (output regs + cycle counter) locally, forwards the rest to SRAM.
// Latency: MMIO ack 2nd cycle after req sampled; SRAM ack 1 cycle after ram_ack_i.
// Backpressure: CPU holds req until ack; SRAM request held until ram_ack_i; req ignored outside IDLE.
module mmio_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'hBFD00400,
    parameter int          NUM_REGS  = 4,
    parameter int          SRAM_AW   = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpu_req_i,
    input  logic                     cpu_we_i,
    input  logic [3:0]               cpu_be_i,
    input  logic [31:0]              cpu_addr_i,
    input  logic [31:0]              cpu_wdata_i,
    output logic [31:0]              cpu_rdata_o,
    output logic                     cpu_ack_o,
    output logic                     ram_req_o,
    output logic                     ram_we_o,
    output logic [3:0]               ram_be_o,
    output logic [SRAM_AW-1:0]       ram_addr_o,
    output logic [31:0]              ram_wdata_o,
    input  logic [31:0]              ram_rdata_i,
    input  logic                     ram_ack_i,
    output logic [NUM_REGS*32-1:0]   gpio_o
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] RAM_WAIT = 2'd1;
    localparam logic [1:0] ACK      = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [31:0]        cpu_rdata_q, cpu_rdata_d;
    logic               ram_req_q, ram_req_d;
    logic               ram_we_q, ram_we_d;
    logic [3:0]         ram_be_q, ram_be_d;
    logic [SRAM_AW-1:0] ram_addr_q, ram_addr_d;
    logic [31:0]        ram_wdata_q, ram_wdata_d;
    logic [31:0]        gpio_q [NUM_REGS];
    logic [31:0]        gpio_d [NUM_REGS];
    logic [31:0]        cnt_q, cnt_d;

    logic [29:0]        word_off;
    logic               mmio_hit;
    logic               cnt_hit;
    logic [31:0]        reg_rdata;
    logic               unused_addr_lsb;

    // Byte-lane merge shared by register and counter writes.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

    // Word offset from the window base; addresses below the base wrap to huge offsets and miss.
    assign word_off        = cpu_addr_i[31:2] - BASE_ADDR[31:2];
    assign mmio_hit        = (word_off <= 30'(NUM_REGS));
    assign cnt_hit         = (word_off == 30'(NUM_REGS));
    assign unused_addr_lsb = ^cpu_addr_i[1:0];

    // Read-back mux over the window; the counter is the word just past the last register.
    always_comb begin
        reg_rdata = cnt_q;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (word_off == 30'(k)) reg_rdata = gpio_q[k];
        end
    end

    // Next-state logic: FSM, register writes, counter, SRAM request capture.
    always_comb begin
        state_d     = state_q;
        cpu_rdata_d = cpu_rdata_q;
        ram_req_d   = ram_req_q;
        ram_we_d    = ram_we_q;
        ram_be_d    = ram_be_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        cnt_d       = cnt_q + 32'd1;
        for (int k = 0; k < NUM_REGS; k++) gpio_d[k] = gpio_q[k];

        case (state_q)
            IDLE: begin
                if (cpu_req_i) begin
                    if (mmio_hit) begin
                        if (cpu_we_i) begin
                            if (cnt_hit) begin
                                // A counter write replaces this cycle's increment.
                                cnt_d = byte_merge(cnt_q, cpu_wdata_i, cpu_be_i);
                            end else begin
                                for (int k = 0; k < NUM_REGS; k++) begin
                                    if (word_off == 30'(k))
                                        gpio_d[k] = byte_merge(gpio_q[k], cpu_wdata_i, cpu_be_i);
                                end
                            end
                        end else begin
                            cpu_rdata_d = reg_rdata;
                        end
                        state_d = ACK;
                    end else begin
                        ram_req_d   = 1'b1;
                        ram_we_d    = cpu_we_i;
                        ram_be_d    = cpu_be_i;
                        ram_addr_d  = cpu_addr_i[SRAM_AW+1:2];
                        ram_wdata_d = cpu_wdata_i;
                        state_d     = RAM_WAIT;
                    end
                end
            end
            RAM_WAIT: begin
                if (ram_ack_i) begin
                    ram_req_d = 1'b0;
                    if (!ram_we_q) cpu_rdata_d = ram_rdata_i;
                    state_d = ACK;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; reset abandons any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cpu_rdata_q <= '0;
            ram_req_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_be_q    <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            cnt_q       <= '0;
            for (int k = 0; k < NUM_REGS; k++) gpio_q[k] <= '0;
        end else begin
            state_q     <= state_d;
            cpu_rdata_q <= cpu_rdata_d;
            ram_req_q   <= ram_req_d;
            ram_we_q    <= ram_we_d;
            ram_be_q    <= ram_be_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            cnt_q       <= cnt_d;
            for (int k = 0; k < NUM_REGS; k++) gpio_q[k] <= gpio_d[k];
        end
    end

    assign cpu_ack_o   = (state_q == ACK);
    assign cpu_rdata_o = cpu_rdata_q;
    assign ram_req_o   = ram_req_q;
    assign ram_we_o    = ram_we_q;
    assign ram_be_o    = ram_be_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_wdata_o = ram_wdata_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_gpio
        assign gpio_o[32*g +: 32] = gpio_q[g];
    end

endmodule

// File: tb/tb_mmio_bridge.sv
// Bench for mmio_bridge: directed scenarios plus random traffic against a transaction-level model.
// Inputs driven on the falling edge; outputs compared 2 time units after each rising edge.
// The SRAM side is emulated with a per-transaction random acknowledge latency.
module tb_mmio_bridge;

    localparam logic [31:0] BASE     = 32'hBFD00400;
    localparam int          NUM_REGS = 4;
    localparam int          SRAM_AW  = 20;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   cpu_req_i = 1'b0;
    logic                   cpu_we_i = 1'b0;
    logic [3:0]             cpu_be_i = '0;
    logic [31:0]            cpu_addr_i = '0;
    logic [31:0]            cpu_wdata_i = '0;
    logic [31:0]            cpu_rdata_o;
    logic                   cpu_ack_o;
    logic                   ram_req_o;
    logic                   ram_we_o;
    logic [3:0]             ram_be_o;
    logic [SRAM_AW-1:0]     ram_addr_o;
    logic [31:0]            ram_wdata_o;
    logic [31:0]            ram_rdata_i = '0;
    logic                   ram_ack_i = 1'b0;
    logic [NUM_REGS*32-1:0] gpio_o;

    mmio_bridge #(.BASE_ADDR(BASE), .NUM_REGS(NUM_REGS), .SRAM_AW(SRAM_AW)) dut (
        .clk(clk), .rst(rst),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_be_i(cpu_be_i),
        .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
        .cpu_rdata_o(cpu_rdata_o), .cpu_ack_o(cpu_ack_o),
        .ram_req_o(ram_req_o), .ram_we_o(ram_we_o), .ram_be_o(ram_be_o),
        .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
        .ram_rdata_i(ram_rdata_i), .ram_ack_i(ram_ack_i),
        .gpio_o(gpio_o)
    );

    always #5 clk = ~clk;

    // Expected outputs after the coming rising edge (set on the falling edge before it).
    logic               chk_en = 1'b0;
    logic               exp_ack = 1'b0;
    logic [31:0]        exp_rdata = '0;
    logic               exp_ram_req = 1'b0;
    logic               exp_ram_we = 1'b0;
    logic [3:0]         exp_ram_be = '0;
    logic [SRAM_AW-1:0] exp_ram_addr = '0;
    logic [31:0]        exp_ram_wdata = '0;
    logic [31:0]        mdl_gpio [NUM_REGS];

    // Counter model: value after edge n is ref_val + (n - ref_edge).
    int          edge_n = 0;
    logic [31:0] cnt_ref_val = '0;
    int          cnt_ref_edge = 0;

    int          n_checks = 0;
    int          n_fail = 0;
    int          last_req_cycles;
    logic [31:0] last_ram_addr;
    logic [31:0] got;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] cnt_at(input int n);
        return cnt_ref_val + 32'(n - cnt_ref_edge);
    endfunction

    // Per-cycle comparison of every observable output against the model.
    always @(posedge clk) begin
        #2;
        if (chk_en) begin
            check("cpu_ack", {31'b0, cpu_ack_o}, {31'b0, exp_ack});
            check("cpu_rdata", cpu_rdata_o, exp_rdata);
            check("ram_req", {31'b0, ram_req_o}, {31'b0, exp_ram_req});
            check("ram_we", {31'b0, ram_we_o}, {31'b0, exp_ram_we});
            check("ram_be", {28'b0, ram_be_o}, {28'b0, exp_ram_be});
            check("ram_addr", 32'(ram_addr_o), 32'(exp_ram_addr));
            check("ram_wdata", ram_wdata_o, exp_ram_wdata);
            for (int k = 0; k < NUM_REGS; k++)
                check($sformatf("gpio%0d", k), gpio_o[32*k +: 32], mdl_gpio[k]);
        end
    end

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst = 1'b1; cpu_req_i = 1'b0; ram_ack_i = 1'b0;
        exp_ack = 1'b0; exp_rdata = '0; exp_ram_req = 1'b0; exp_ram_we = 1'b0;
        exp_ram_be = '0; exp_ram_addr = '0; exp_ram_wdata = '0;
        for (int k = 0; k < NUM_REGS; k++) mdl_gpio[k] = '0;
        chk_en = 1'b1;
        repeat (cycles - 1) @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cnt_ref_edge = edge_n;
        cnt_ref_val  = '0;
    endtask

    // One complete CPU transaction; rd returns what the bus showed with the ack.
    task automatic do_txn(input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wd, input int lat, input logic [31:0] rrd,
                          output logic [31:0] rd);
        logic [31:0] off;
        int          idx;
        int          m;
        logic [31:0] cur;
        @(negedge clk);
        cpu_req_i = 1'b1; cpu_we_i = we; cpu_be_i = be; cpu_addr_i = addr; cpu_wdata_i = wd;
        off = addr - BASE;
        m   = edge_n + 1;
        if ((off >> 2) <= 32'(NUM_REGS)) begin
            idx = int'(off[31:2]);
            if (idx < NUM_REGS) begin
                if (we) mdl_gpio[idx] = merge(mdl_gpio[idx], wd, be);
                else    exp_rdata = mdl_gpio[idx];
            end else begin
                cur = cnt_at(m - 1);
                if (we) begin
                    cnt_ref_val  = merge(cur, wd, be);
                    cnt_ref_edge = m;
                end else begin
                    exp_rdata = cur;
                end
            end
            exp_ack = 1'b1;
            last_req_cycles = 0;
        end else begin
            exp_ram_req = 1'b1; exp_ram_we = we; exp_ram_be = be;
            exp_ram_addr = addr[SRAM_AW+1:2]; exp_ram_wdata = wd;
            last_req_cycles = 0;
            for (int i = 1; i <= lat; i++) begin
                @(negedge clk);
                if (ram_req_o) last_req_cycles++;
                if (i == 1) last_ram_addr = 32'(ram_addr_o);
                if (i < lat) begin
                    ram_rdata_i = $urandom;
                end else begin
                    ram_ack_i = 1'b1; ram_rdata_i = rrd;
                    exp_ram_req = 1'b0; exp_ack = 1'b1;
                    if (!we) exp_rdata = rrd;
                end
            end
        end
        @(negedge clk);
        rd = cpu_rdata_o;
        cpu_req_i = 1'b0; ram_ack_i = 1'b0; ram_rdata_i = $urandom;
        exp_ack = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        int          kind;
        for (int k = 0; k < NUM_REGS; k++) mdl_gpio[k] = '0;

        // Reset, then an immediate counter read.
        do_reset(2);
        do_txn(1'b0, 4'hF, BASE + 32'(4*NUM_REGS), 32'h0, 1, 32'h0, got);
        check("lit_cnt_after_reset_le3", {31'b0, got <= 32'd3}, 32'd1);

        // Full-word register write and read-back.
        do_txn(1'b1, 4'hF, BASE, 32'h0000A5A5, 1, 32'h0, got);
        check("lit_gpio0", gpio_o[31:0], 32'h0000A5A5);
        check("lit_mmio_no_ram_req", last_req_cycles, 32'd0);
        do_txn(1'b0, 4'hF, BASE, 32'h0, 1, 32'h0, got);
        check("lit_read_reg0", got, 32'h0000A5A5);

        // Byte-enable merge on reg2.
        do_txn(1'b1, 4'hF, BASE + 32'd8, 32'h11223344, 1, 32'h0, got);
        do_txn(1'b1, 4'b0101, BASE + 32'd8, 32'hAABBCCDD, 1, 32'h0, got);
        do_txn(1'b0, 4'hF, BASE + 32'd8, 32'h0, 1, 32'h0, got);
        check("lit_read_reg2_merge", got, 32'h11BB33DD);
        do_txn(1'b1, 4'b0000, BASE + 32'd8, 32'hFFFFFFFF, 1, 32'h0, got);
        check("lit_gpio2_be0", gpio_o[95:64], 32'h11BB33DD);

        // SRAM read with a 3-cycle acknowledge.
        do_txn(1'b0, 4'hF, 32'h80001234, 32'h0, 3, 32'hDEADBEEF, got);
        check("lit_sram_rdata", got, 32'hDEADBEEF);
        check("lit_sram_addr", last_ram_addr, 32'h0000048D);
        check("lit_sram_req_cycles", last_req_cycles, 32'd3);

        // Counter load and wrap through zero.
        do_txn(1'b1, 4'hF, BASE + 32'(4*NUM_REGS), 32'hFFFFFFFE, 1, 32'h0, got);
        do_txn(1'b0, 4'hF, BASE + 32'(4*NUM_REGS), 32'h0, 1, 32'h0, got);
        check("lit_cnt_wrap_a", got, 32'hFFFFFFFF);
        do_txn(1'b0, 4'hF, BASE + 32'(4*NUM_REGS), 32'h0, 1, 32'h0, got);
        check("lit_cnt_wrap_b", got, 32'h00000001);

        // Word just past the counter belongs to SRAM.
        do_txn(1'b0, 4'hF, BASE + 32'(4*(NUM_REGS+1)), 32'h0, 2, 32'h5A5A0001, got);
        check("lit_beyond_cnt_sram", last_req_cycles, 32'd2);
        check("lit_beyond_cnt_rdata", got, 32'h5A5A0001);

        // Reset while waiting on SRAM, then a stray late ack.
        @(negedge clk);
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_be_i = 4'hF;
        cpu_addr_i = 32'h00001000; cpu_wdata_i = 32'h12345678;
        exp_ram_req = 1'b1; exp_ram_we = 1'b0; exp_ram_be = 4'hF;
        exp_ram_addr = 20'h00400; exp_ram_wdata = 32'h12345678;
        @(negedge clk);
        @(negedge clk);
        do_reset(2);
        @(negedge clk);
        ram_ack_i = 1'b1; ram_rdata_i = 32'hBAD0BAD0;
        @(negedge clk);
        ram_ack_i = 1'b0;
        do_txn(1'b0, 4'hF, BASE, 32'h0, 1, 32'h0, got);
        check("lit_reg0_after_reset", got, 32'h0);
        do_txn(1'b1, 4'b0011, 32'h00002000, 32'hCAFEF00D, 1, 32'h0, got);

        // Random traffic across registers, counter, and SRAM.
        for (int t = 0; t < 200; t++) begin
            kind = $urandom_range(0, 6);
            case (kind)
                0, 1, 2: a = BASE + 32'(4 * $urandom_range(0, NUM_REGS - 1)) + 32'($urandom_range(0, 3));
                3:       a = BASE + 32'(4 * NUM_REGS) + 32'($urandom_range(0, 3));
                4:       a = BASE + 32'(4 * (NUM_REGS + 1)) + 32'(4 * $urandom_range(0, 7));
                5:       a = BASE - 32'(4 * $urandom_range(1, 4));
                default: a = $urandom;
            endcase
            do_txn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom,
                   $urandom_range(1, 4), $urandom, got);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mmio_bridge.md
Name: mmio_bridge

Overview:
Data-side bus bridge between the CPU memory stage and the external SRAM controller. It decodes a parametrised MMIO window, by default at 0xBFD00400, and serves it locally. The window holds NUM_REGS byte-writable, read-back-capable output registers (LED, 7-segment, ...) plus a free-running cycle counter. All other addresses are forwarded to SRAM through a req/ack handshake. A 3-state FSM gives fixed MMIO latency and variable SRAM latency.

Parameters:
BASE_ADDR, 32'hBFD00400, byte address of MMIO word 0; must be word-aligned
NUM_REGS, 4, number of 32-bit output registers, 1..16
SRAM_AW, 20, SRAM word-address width

Ports:
clk  in  1  clock
rst  in  1  reset
cpu_req_i  in  1  request valid; held stable with addr/we/be/wdata until cpu_ack_o
cpu_we_i  in  1  1=write, 0=read
cpu_be_i  in  4  byte enables, bit i = byte lane [8i+7:8i]
cpu_addr_i  in  32  byte address
cpu_wdata_i  in  32  write data
cpu_rdata_o  out  32  read data, valid while cpu_ack_o=1
cpu_ack_o  out  1  one-cycle completion pulse
ram_req_o  out  1  SRAM request, held until ram_ack_i
ram_we_o  out  1  SRAM write
ram_be_o  out  4  SRAM byte enables
ram_addr_o  out  SRAM_AW  SRAM word address = cpu_addr_i[SRAM_AW+1:2]
ram_wdata_o  out  32  SRAM write data
ram_rdata_i  in  32  SRAM read data, valid with ram_ack_i
ram_ack_i  in  1  SRAM completion, may arrive 1..N cycles after ram_req_o
gpio_o  out  NUM_REGS*32  register k on bits [32k+31:32k]

Behaviour:
- Reset: rst is synchronous, active-high. On reset:
  - state=IDLE, cpu_ack_o=0, cpu_rdata_o=0.
  - ram_req_o=0, ram_we_o=0, ram_be_o=0, ram_addr_o=0, ram_wdata_o=0.
  - All gpio registers=0, counter=0.
  - Reset mid-transaction abandons it with no ack. A late ram_ack_i is ignored in IDLE.
- MMIO hit: word index w = (cpu_addr_i - BASE_ADDR)>>2, with 0 <= w <= NUM_REGS. Address bits [1:0] are ignored.
  - w<NUM_REGS selects gpio register w.
  - w==NUM_REGS selects the counter.
  - Every other address goes to SRAM.
- Counter: 32-bit; increments every cycle after reset; wraps 0xFFFFFFFF->0.
  - A write merges enabled bytes of wdata into the current value; the merged value is loaded that cycle instead of the increment.
- FSM states IDLE, RAM_WAIT, ACK.
  - IDLE, req=1, MMIO hit:
    - Write: enabled bytes of the target register are updated at this edge. be=0000 changes nothing but still acks.
    - Read: cpu_rdata_o<=register value; counter reads return its pre-increment value at this edge.
    - Next state ACK.
  - IDLE, req=1, SRAM: register ram_req_o=1 with we/be/addr/wdata captured from cpu inputs. Next state RAM_WAIT.
  - RAM_WAIT:
    - Hold all ram_* outputs.
    - On ram_ack_i=1: ram_req_o<=0; cpu_rdata_o<=ram_rdata_i for reads, unchanged for writes; next state ACK.
    - Otherwise stay.
  - ACK: cpu_ack_o=1 for exactly this cycle; next state IDLE. cpu_req_i is ignored in ACK.
- Latency: MMIO = ack in the 2nd cycle after req is sampled. SRAM = ack 1 cycle after ram_ack_i. Back-to-back requests are spaced at least 2 cycles apart.
- cpu_ack_o is registered (state==ACK decoded from the state register, no combinational path from inputs). gpio_o is driven directly from registers.
- Unaffected registers hold their value during SRAM traffic.
- The bridge issues no SRAM request for MMIO addresses.

Test Plan:
- Reset: rst high 2 cycles -> gpio_o=0, cpu_ack_o=0, ram_req_o=0; a counter read immediately after returns a small value (≤3).
- Write 0x0000A5A5, be=1111, to 0xBFD00400 -> gpio reg0=0x0000A5A5 one cycle after req; ack in cycle 2; ram_req_o never asserts. Read back returns 0x0000A5A5.
- Byte-enable merge: reg2=0x11223344, then write 0xAABBCCDD with be=0101 to 0xBFD00408 -> reg2=0x11BB33DD.
- SRAM read at 0x80001234 with ram_ack_i after 3 cycles, ram_rdata_i=0xDEADBEEF:
  - ram_addr_o=0x0048D, ram_req_o held 3 cycles.
  - cpu_ack_o one cycle after ram_ack_i with rdata 0xDEADBEEF.
- Counter: write 0xFFFFFFFE to BASE+4*NUM_REGS -> successive reads show wrap through 0; an address beyond the counter word (BASE+4*(NUM_REGS+1)) goes to SRAM.
- Assert rst during RAM_WAIT -> ram_req_o=0 and no cpu_ack_o; a ram_ack_i arriving afterward is ignored; the next request completes normally.
